// File: rtl/sauria_psum_packer.sv
`default_nettype none
// ============================================================================
// Module   : sauria_psum_packer
// Purpose  : Packs systolic-array psum columns into SRAM C words, one word per
//            unstalled cycle, with per-element write masks and address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module sauria_psum_packer #(
    parameter int Y       = 8,
    parameter int OC_W    = 32,
    parameter int SRAMC_W = 128,
    parameter int ADRC_W  = 12,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [ADRC_W-1:0]         i_base_addr,
    input  logic [CNT_W-1:0]          i_n_cols,
    input  logic                      i_col_valid,
    input  logic [Y*OC_W-1:0]         i_col_data,
    output logic                      o_col_ready,
    input  logic                      i_sram_stall,
    output logic                      o_sram_wren,
    output logic [ADRC_W-1:0]         o_sram_addr,
    output logic [SRAMC_W-1:0]        o_sram_wdata,
    output logic [SRAMC_W/OC_W-1:0]   o_sram_wmask,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int c_N     = SRAMC_W / OC_W;
    localparam int c_WORDS = (Y + c_N - 1) / c_N;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_COL_W = Y * OC_W;
    localparam int c_PAD_W = c_WORDS * SRAMC_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WORDS - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_COL = 2'd1;
    localparam logic [1:0] c_EMIT     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_n_cols;
    logic [CNT_W-1:0]    r_col_cnt;
    logic [c_COL_W-1:0]  r_col;
    logic [c_IDX_W-1:0]  r_word_idx;
    logic [ADRC_W-1:0]   r_addr;
    logic [SRAMC_W-1:0]  r_wdata;
    logic [c_N-1:0]      r_wmask;
    logic                r_col_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_write;
    logic [CNT_W-1:0]    w_col_cnt_nxt;
    logic [c_COL_W-1:0]  w_src_col;
    logic [c_PAD_W-1:0]  w_pad;
    logic [c_IDX_W-1:0]  w_sel_idx;
    logic [SRAMC_W-1:0]  w_next_word;
    logic [c_N-1:0]      w_next_mask;

    assign w_accept      = r_col_ready & i_col_valid;
    assign w_write       = (r_state == c_EMIT) & ~i_sram_stall;
    assign w_col_cnt_nxt = r_col_cnt + 1'b1;

    // Word 0 is built straight from the incoming column so the first write
    // can be presented the cycle right after acceptance.
    assign w_src_col = (r_state == c_WAIT_COL) ? i_col_data : r_col;

    generate
        if (c_PAD_W > c_COL_W) begin : g_pad
            assign w_pad = {{(c_PAD_W - c_COL_W){1'b0}}, w_src_col};
        end else begin : g_nopad
            assign w_pad = w_src_col;
        end
    endgenerate

    always_comb begin
        w_sel_idx   = (r_state == c_EMIT) ? r_word_idx + 1'b1 : '0;
        w_next_word = '0;
        w_next_mask = '0;
        for (int w = 0; w < c_WORDS; w++) begin
            if (w_sel_idx == c_IDX_W'(w)) begin
                w_next_word = w_pad[w*SRAMC_W +: SRAMC_W];
                for (int k = 0; k < c_N; k++) begin
                    w_next_mask[k] = (w * c_N + k) < Y;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_IDLE;
            r_n_cols    <= '0;
            r_col_cnt   <= '0;
            r_col       <= '0;
            r_word_idx  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_col_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_addr    <= i_base_addr;
                        r_n_cols  <= i_n_cols;
                        r_col_cnt <= '0;
                        r_busy    <= 1'b1;
                        if (i_n_cols == '0) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= c_WAIT_COL;
                            r_col_ready <= 1'b1;
                        end
                    end
                end
                c_WAIT_COL: begin
                    if (w_accept) begin
                        r_col       <= i_col_data;
                        r_word_idx  <= '0;
                        r_wdata     <= w_next_word;
                        r_wmask     <= w_next_mask;
                        r_col_ready <= 1'b0;
                        r_state     <= c_EMIT;
                    end
                end
                c_EMIT: begin
                    // A stall simply skips this branch, so addr/data/mask hold.
                    if (w_write) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_word_idx == c_LAST_IDX) begin
                            r_col_cnt <= w_col_cnt_nxt;
                            if (w_col_cnt_nxt == r_n_cols) begin
                                r_state <= c_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= c_WAIT_COL;
                                r_col_ready <= 1'b1;
                            end
                        end else begin
                            r_word_idx <= w_sel_idx;
                            r_wdata    <= w_next_word;
                            r_wmask    <= w_next_mask;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign o_col_ready  = r_col_ready;
    assign o_sram_wren  = w_write;
    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_sram_wmask = r_wmask;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sauria_psum_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sauria_psum_packer
// Purpose  : Randomized bench for two packer instances (Y=8 and Y=6) sharing
//            one stimulus stream, checked against a queue-based write model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sauria_psum_packer;

    localparam int c_N   = 4;
    localparam int c_YA  = 8;
    localparam int c_YB  = 6;
    localparam int c_WDS = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [11:0]  base_addr;
    logic [15:0]  n_cols;
    logic         col_valid;
    logic [255:0] col_data;
    logic         sram_stall;

    logic         col_ready_a, wren_a, busy_a, done_a;
    logic [11:0]  addr_a;
    logic [127:0] wdata_a;
    logic [3:0]   wmask_a;
    logic         col_ready_b, wren_b, busy_b, done_b;
    logic [11:0]  addr_b;
    logic [127:0] wdata_b;
    logic [3:0]   wmask_b;

    sauria_psum_packer u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_n_cols(n_cols), .i_col_valid(col_valid), .i_col_data(col_data),
        .o_col_ready(col_ready_a), .i_sram_stall(sram_stall), .o_sram_wren(wren_a),
        .o_sram_addr(addr_a), .o_sram_wdata(wdata_a), .o_sram_wmask(wmask_a),
        .o_busy(busy_a), .o_done(done_a)
    );

    sauria_psum_packer #(.Y(c_YB)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
        .i_n_cols(n_cols), .i_col_valid(col_valid), .i_col_data(col_data[191:0]),
        .o_col_ready(col_ready_b), .i_sram_stall(sram_stall), .o_sram_wren(wren_b),
        .o_sram_addr(addr_b), .o_sram_wdata(wdata_b), .o_sram_wmask(wmask_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int stall_mode;
    bit prev_accept, prev_wren, prev_start0;

    logic [11:0]  q_addr[$];
    logic [127:0] q_data_a[$];
    logic [3:0]   q_mask_a[$];
    logic [127:0] q_data_b[$];
    logic [3:0]   q_mask_b[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected writes of one column: element e lands in word e/N, slot e%N.
    task automatic push_col(input logic [11:0] addr0, input logic [255:0] col);
        for (int w = 0; w < c_WDS; w++) begin
            logic [127:0] da, db;
            logic [3:0]   ma, mb;
            da = '0; db = '0; ma = '0; mb = '0;
            for (int k = 0; k < c_N; k++) begin
                int e;
                e = w * c_N + k;
                if (e < c_YA) begin da[k*32 +: 32] = col[e*32 +: 32]; ma[k] = 1'b1; end
                if (e < c_YB) begin db[k*32 +: 32] = col[e*32 +: 32]; mb[k] = 1'b1; end
            end
            q_addr.push_back(12'(addr0 + 12'(w)));
            q_data_a.push_back(da); q_mask_a.push_back(ma);
            q_data_b.push_back(db); q_mask_b.push_back(mb);
        end
    endtask

    task automatic flush_model();
        q_addr.delete(); q_data_a.delete(); q_mask_a.delete();
        q_data_b.delete(); q_mask_b.delete();
    endtask

    task automatic monitor_step();
        if (rst) begin
            prev_accept = 0; prev_wren = 0; prev_start0 = 0;
            return;
        end
        if (prev_accept && !sram_stall) check("first_write_latency", wren_a, 1);
        if (wren_a) begin
            check("write_expected", q_addr.size() > 0, 1);
            check("wren_while_busy", busy_a, 1);
            check("wren_b", wren_b, 1);
            if (q_addr.size() > 0) begin
                check("addr_a", addr_a, q_addr[0]);
                check("addr_b", addr_b, q_addr[0]);
                check("wdata_a", wdata_a, q_data_a[0]);
                check("wmask_a", wmask_a, q_mask_a[0]);
                check("wdata_b", wdata_b, q_data_b[0]);
                check("wmask_b", wmask_b, q_mask_b[0]);
                void'(q_addr.pop_front()); void'(q_data_a.pop_front());
                void'(q_mask_a.pop_front()); void'(q_data_b.pop_front());
                void'(q_mask_b.pop_front());
            end
        end
        if (done_a) begin
            check("done_timing", prev_wren | prev_start0, 1);
            check("done_drained", q_addr.size(), 0);
            check("done_b", done_b, 1);
        end
        prev_accept = col_valid & col_ready_a;
        prev_wren   = wren_a;
        prev_start0 = start & (n_cols == 16'd0) & ~busy_a;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done_a) got = 1;
        end
        check("done_timeout", got, 1);
    endtask

    task automatic run_job(input logic [11:0] base, input int ncols, input bit seq);
        logic [255:0] cols[$];
        logic [255:0] col;
        bit got;
        for (int c = 0; c < ncols; c++) begin
            for (int j = 0; j < c_YA; j++) col[j*32 +: 32] = seq ? 32'(c * c_YA + j) : $urandom;
            cols.push_back(col);
            push_col(12'(base + 12'(2 * c)), col);
        end
        @(posedge clk); #1;
        start = 1; base_addr = base; n_cols = 16'(ncols);
        @(posedge clk); #1;
        start = 0;
        if (ncols == 0) begin
            @(negedge clk);
            check("zero_done", done_a, 1);
            check("zero_ready", col_ready_a, 0);
            return;
        end
        for (int c = 0; c < ncols; c++) begin
            if (!seq) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                // Start while busy must not disturb the running job.
                if ($urandom_range(0, 3) == 0) begin
                    start = 1; base_addr = ~base; n_cols = 16'(ncols + 5);
                    @(posedge clk); #1;
                    start = 0;
                end
            end
            col_valid = 1; col_data = cols[c];
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (col_ready_a) got = 1;
            end
            check("col_accept_timeout", got, 1);
            @(posedge clk); #1;
            col_valid = 0; col_data = {8{32'hDEAD_BEEF}};
        end
        wait_done();
    endtask

    initial begin
        logic [255:0] col;
        bit got;
        n_checks = 0; n_errors = 0; stall_mode = 0;
        rst = 1; start = 0; base_addr = '0; n_cols = '0;
        col_valid = 0; col_data = '0; sram_stall = 0;
        prev_accept = 0; prev_wren = 0; prev_start0 = 0;

        fork
            forever begin @(negedge clk); monitor_step(); end
            forever begin
                @(posedge clk); #1;
                if (stall_mode == 1) sram_stall = ($urandom_range(0, 3) == 0);
                else if (stall_mode == 0) sram_stall = 0;
            end
            begin
                #2_000_000;
                $display("FAIL global_timeout: observed running, expected finished");
                $fatal(1);
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", col_ready_a, 0);
        check("rst_wren", wren_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_wmask", wmask_a, 0);
        @(posedge clk); #1 rst = 0;

        // Elements 0..15 across two columns at 0x010
        run_job(12'h010, 2, 1);
        // Address wrap from all-ones
        run_job(12'hFFF, 1, 0);

        // Empty job, with a second start landing in the DONE cycle
        @(posedge clk); #1;
        start = 1; base_addr = 12'h055; n_cols = 16'd0;
        @(posedge clk); #1;
        n_cols = 16'd3;
        @(negedge clk);
        check("empty_done", done_a, 1);
        check("empty_ready", col_ready_a, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check("done_start_ignored_busy", busy_a, 0);
        check("done_start_ignored_done", done_a, 0);
        @(negedge clk);
        check("idle_ready", col_ready_a, 0);

        // Three stalled cycles on the first word
        stall_mode = 2; sram_stall = 1;
        for (int j = 0; j < c_YA; j++) col[j*32 +: 32] = 32'(100 + j);
        push_col(12'h100, col);
        @(posedge clk); #1;
        start = 1; base_addr = 12'h100; n_cols = 16'd1;
        @(posedge clk); #1;
        start = 0; col_valid = 1; col_data = col;
        @(posedge clk); #1 col_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wren", wren_a, 0);
            check("stall_addr", addr_a, 12'h100);
            check("stall_wdata", wdata_a, q_data_a[0]);
            check("stall_wmask", wmask_a, q_mask_a[0]);
        end
        @(posedge clk); #1 sram_stall = 0;
        @(negedge clk);
        check("stall_release_wren", wren_a, 1);
        wait_done();
        stall_mode = 0;

        // Random jobs with random stalls
        stall_mode = 1;
        for (int j = 0; j < 12; j++) run_job(12'($urandom), $urandom_range(0, 4), 0);
        stall_mode = 0;

        // Reset in the middle of an emit; the job must not resume
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < c_YA; j++) col[j*32 +: 32] = $urandom;
            push_col(12'(12'h200 + 12'(2 * c)), col);
        end
        @(posedge clk); #1;
        start = 1; base_addr = 12'h200; n_cols = 16'd3;
        @(posedge clk); #1;
        start = 0; col_valid = 1; col_data = col;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (col_ready_a) got = 1;
        end
        check("rst_job_accept", got, 1);
        @(posedge clk); #1;
        col_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        flush_model();
        @(negedge clk);
        check("midrst_ready", col_ready_a, 0);
        check("midrst_wren", wren_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_addr", addr_a, 0);
        check("midrst_wdata", wdata_a, 0);
        check("midrst_wmask", wmask_a, 0);
        @(posedge clk); #1 col_valid = 1;
        repeat (3) begin
            @(negedge clk);
            check("no_resume_busy", busy_a, 0);
            check("no_resume_wren", wren_a, 0);
        end
        @(posedge clk); #1 col_valid = 0;
        run_job(12'h300, 2, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
